// File: rtl/fb_pkg.sv
// Constants and state encoding shared by the frame-buffer scan-out reader
// and the drawing path, so both ends agree on buffer placement.
package fb_pkg;

  localparam logic [21:0] FB_BASE0       = 22'h100000;
  localparam logic [21:0] FB_BASE1       = 22'h200000;
  localparam int          WORDS_PER_LINE = 40;
  localparam int          LINES          = 480;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t IDLE      = 3'd0;
  localparam fetch_state_t ISSUE     = 3'd1;
  localparam fetch_state_t WAIT_AC   = 3'd2;
  localparam fetch_state_t WAIT_DATA = 3'd3;
  localparam fetch_state_t NEXT      = 3'd4;

  // Lines are stored back to back, so the line stride equals the line length.
  function automatic logic [21:0] line_base_addr(input logic [21:0] base,
                                                 input logic [8:0]  idx);
    return base + 22'(idx) * 22'(WORDS_PER_LINE);
  endfunction

endpackage

// File: rtl/line_buffer_pingpong.sv
// Two-bank line buffer: one write port for the SDRAM fetch, one registered
// read port for the display side.
module line_buffer_pingpong
  import fb_pkg::*;
(
  input  logic         clk,
  input  logic         we,
  input  logic         wr_bank,
  input  logic [5:0]   wr_word,
  input  logic [127:0] wr_data,
  input  logic         rd_bank,
  input  logic [5:0]   rd_word,
  output logic [127:0] rd_data
);

  logic [127:0] mem [2][WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_word] <= wr_data;
    end
    rd_data <= mem[rd_bank][rd_word];
  end

endmodule

// File: rtl/fb_scanout_reader.sv
// Fetches display lines from the SDRAM frame buffer the drawer is not writing
// into a ping-pong line buffer, and serves palette indices to the colour mapper.
module fb_scanout_reader
  import fb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_flip,
  input  logic         line_req,
  input  logic [8:0]   line_idx,
  input  logic         sdram_wait,
  input  logic         sdram_ac,
  input  logic         sdram_rdvalid,
  input  logic [127:0] sdram_rddata,
  output logic         sdram_rd,
  output logic [21:0]  sdram_addr,
  input  logic [9:0]   rd_x,
  output logic [7:0]   pixel,
  output logic         busy,
  output logic         underrun
);

  fetch_state_t state;
  logic         fill_bank;
  logic [5:0]   word_cnt;
  logic [21:0]  disp_base;
  logic [21:0]  line_base;
  logic         drop_pending;

  logic         req_ok;
  logic [21:0]  next_disp_base;
  logic         accept_data;

  logic         rd_in_range;
  logic [5:0]   rd_word;
  logic [127:0] rd_data;
  logic [3:0]   byte_sel;
  logic         pix_valid;

  assign req_ok         = line_req && (line_idx < 9'(LINES));
  assign next_disp_base = (line_idx == 9'd0) ? (frame_flip ? FB_BASE0 : FB_BASE1)
                                             : disp_base;
  assign accept_data    = (state == WAIT_DATA) && sdram_rdvalid && !drop_pending;
  assign busy           = (state != IDLE);

  // An abort with a request already accepted leaves one stale rdvalid in
  // flight; drop_pending swallows it wherever it lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      fill_bank    <= 1'b0;
      word_cnt     <= 6'd0;
      disp_base    <= FB_BASE0;
      line_base    <= 22'd0;
      sdram_rd     <= 1'b0;
      sdram_addr   <= 22'd0;
      underrun     <= 1'b0;
      drop_pending <= 1'b0;
    end else begin
      if (sdram_rdvalid && drop_pending) begin
        drop_pending <= 1'b0;
      end
      if (req_ok) begin
        fill_bank <= ~fill_bank;
        disp_base <= next_disp_base;
        line_base <= line_base_addr(next_disp_base, line_idx);
        word_cnt  <= 6'd0;
        sdram_rd  <= 1'b0;
        state     <= ISSUE;
        if (state != IDLE) begin
          underrun <= 1'b1;
        end
        if ((state == WAIT_DATA) || ((state == WAIT_AC) && sdram_ac)) begin
          drop_pending <= 1'b1;
        end
      end else begin
        case (state)
          ISSUE: begin
            if (!sdram_wait) begin
              sdram_rd   <= 1'b1;
              sdram_addr <= line_base + 22'(word_cnt);
              state      <= WAIT_AC;
            end
          end
          WAIT_AC: begin
            if (sdram_ac) begin
              sdram_rd <= 1'b0;
              state    <= WAIT_DATA;
            end
          end
          WAIT_DATA: begin
            if (accept_data) begin
              state <= NEXT;
            end
          end
          NEXT: begin
            if (word_cnt == 6'(WORDS_PER_LINE - 1)) begin
              state <= IDLE;
            end else begin
              word_cnt <= word_cnt + 6'd1;
              state    <= ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  line_buffer_pingpong u_linebuf (
    .clk     (clk),
    .we      (accept_data),
    .wr_bank (fill_bank),
    .wr_word (word_cnt),
    .wr_data (sdram_rddata),
    .rd_bank (~fill_bank),
    .rd_word (rd_word),
    .rd_data (rd_data)
  );

  assign rd_in_range = (rd_x < 10'd640);
  assign rd_word     = rd_in_range ? rd_x[9:4] : 6'd0;

  // The RAM read is the pipeline register; byte select and blanking ride alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_sel  <= 4'd0;
      pix_valid <= 1'b0;
    end else begin
      byte_sel  <= rd_x[3:0];
      pix_valid <= rd_in_range;
    end
  end

  assign pixel = pix_valid ? rd_data[{byte_sel, 3'b000} +: 8] : 8'h00;

endmodule
